// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg
//   Shared definitions for the load/store bus responders: access-size
//   encodings carried on HB, the timer register word indices and the CTRL
//   bit positions, plus a helper that yields the read-data mask for a size.
package bus_timer_pkg;

    // HB access-size encodings (2'b11 is reserved and always rejected)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Timer register word indices (byte offset = index * 4)
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_COUNT    = 2;
    localparam int REG_COMPARE  = 3;
    localparam int REG_PRESCALE = 4;
    localparam int NUM_REGS     = 5;

    // CTRL bit indices
    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_W           = 3;

    // Right-justified read data is zero-extended to the access size.
    function automatic logic [31:0] size_mask(input logic [1:0] hb);
        case (hb)
            SZ_BYTE: size_mask = 32'h0000_00FF;
            SZ_HALF: size_mask = 32'h0000_FFFF;
            SZ_WORD: size_mask = 32'hFFFF_FFFF;
            default: size_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/bus_timer_lane_ctrl.sv
// bus_lane_ctrl
//   Combinational lane decoder for a bus responder. From the low address
//   bits, the access size and the strobes it derives the byte enables,
//   an error flag (reserved size, misalignment, read and write together)
//   and the bit shift that moves the addressed lane to/from bit 0.
//   Ports:
//     addr_lo  in  2  byte address bits [1:0]
//     hb       in  2  access size
//     we, re   in  1  write / read strobes
//     byte_en  out 4  lanes touched by the access
//     err      out 1  access must be rejected
//     rd_shift out 5  lane-to-bit-0 shift amount (addr_lo * 8)
import bus_timer_pkg::*;

module bus_lane_ctrl (
    input  logic [1:0] addr_lo,
    input  logic [1:0] hb,
    input  logic       we,
    input  logic       re,
    output logic [3:0] byte_en,
    output logic       err,
    output logic [4:0] rd_shift
);

    always_comb begin
        byte_en = 4'b0000;
        err     = 1'b0;
        case (hb)
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: begin
                err     = addr_lo[0];
                byte_en = addr_lo[0] ? 4'b0000 : (4'b0011 << addr_lo);
            end
            SZ_WORD: begin
                err     = (addr_lo != 2'b00);
                byte_en = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            end
            default: err = 1'b1;
        endcase
        if (we && re) begin
            err = 1'b1;
        end
    end

    assign rd_shift = {addr_lo, 3'b000};

endmodule

// File: rtl/bus_timer.sv
// bus_timer
//   Memory-mapped timer on the core load/store bus. Byte/half/word accesses
//   hit a five-register file (CTRL, STATUS, COUNT, COMPARE, PRESCALE); every
//   accepted access is answered by a one-cycle o_ACK the following cycle,
//   qualified by o_ERR. A prescaled 32-bit up-counter compares against
//   COMPARE, sets the sticky MATCH flag and drives the o_IRQ level.
//   Ports:
//     i_clk, i_rst     clock (rising edge), asynchronous active-high reset
//     i_CS             slave select
//     i_ADDR [31:0]    byte address, only [OFFS_W-1:0] decoded
//     i_WDATA [31:0]   right-justified write data
//     i_WE, i_RE       write / read strobes
//     i_HB [1:0]       access size
//     o_RDATA [31:0]   right-justified, zero-extended read data
//     o_ACK, o_ERR     response pulse and its error qualifier
//     o_IRQ            interrupt level (MATCH & IRQ_EN)
import bus_timer_pkg::*;

module bus_timer #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF,
    parameter int          OFFS_W      = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_CS,
    input  logic [31:0] i_ADDR,
    input  logic [31:0] i_WDATA,
    input  logic        i_WE,
    input  logic        i_RE,
    input  logic [1:0]  i_HB,
    output logic [31:0] o_RDATA,
    output logic        o_ACK,
    output logic        o_ERR,
    output logic        o_IRQ
);

    logic [CTRL_W-1:0]     ctrl_reg,     ctrl_next;
    logic                  match_reg,    match_next;
    logic [31:0]           count_reg,    count_next;
    logic [31:0]           compare_reg,  compare_next;
    logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
    logic [PRESCALE_W-1:0] psc_cnt_reg,  psc_cnt_next;
    logic [31:0]           rdata_next;
    logic                  irq_next;

    logic                  acc, acc_err, wr_ok, rd_ok, tick, match_hit;
    logic [3:0]            byte_en;
    logic                  lane_err;
    logic [4:0]            rd_shift;
    logic [OFFS_W-3:0]     widx;
    logic [NUM_REGS-1:0]   sel;
    logic [31:0]           reg_rd, wdata_lane, merged;
    logic                  unused_addr;

    assign unused_addr = ^i_ADDR[31:OFFS_W];

    bus_lane_ctrl u_lane (
        .addr_lo  (i_ADDR[1:0]),
        .hb       (i_HB),
        .we       (i_WE),
        .re       (i_RE),
        .byte_en  (byte_en),
        .err      (lane_err),
        .rd_shift (rd_shift)
    );

    // One-hot register select from the word index inside the window
    assign widx = i_ADDR[OFFS_W-1:2];
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign sel[gi] = (widx == (OFFS_W-2)'(gi));
        end
    endgenerate

    assign acc     = i_CS & (i_WE | i_RE);
    assign acc_err = lane_err | ~(|sel);
    assign wr_ok   = acc & i_WE & ~acc_err;
    assign rd_ok   = acc & i_RE & ~acc_err;

    // Full 32-bit view of the selected register; unimplemented bits read 0
    always_comb begin
        reg_rd = 32'h0;
        if (sel[REG_CTRL])     reg_rd = 32'(ctrl_reg);
        if (sel[REG_STATUS])   reg_rd = 32'(match_reg);
        if (sel[REG_COUNT])    reg_rd = count_reg;
        if (sel[REG_COMPARE])  reg_rd = compare_reg;
        if (sel[REG_PRESCALE]) reg_rd = 32'(prescale_reg);
    end

    // Steer narrow write data onto its lane and merge with the old value
    assign wdata_lane = i_WDATA << rd_shift;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = byte_en[gi] ? wdata_lane[8*gi +: 8]
                                                   : reg_rd[8*gi +: 8];
        end
    endgenerate

    // Prescaler; a PRESCALE write restarts the division from zero
    always_comb begin
        tick         = 1'b0;
        psc_cnt_next = psc_cnt_reg;
        if (ctrl_reg[CTRL_EN]) begin
            if (psc_cnt_reg == prescale_reg) begin
                psc_cnt_next = '0;
                tick         = 1'b1;
            end else begin
                psc_cnt_next = psc_cnt_reg + PRESCALE_W'(1);
            end
        end
        if (wr_ok && sel[REG_PRESCALE]) begin
            psc_cnt_next = '0;
        end
    end

    assign match_hit = tick & (count_reg == compare_reg);

    always_comb begin
        count_next    = count_reg;
        ctrl_next     = ctrl_reg;
        compare_next  = compare_reg;
        prescale_next = prescale_reg;
        match_next    = match_reg;

        if (tick) begin
            if (match_hit && ctrl_reg[CTRL_AUTO_RELOAD]) count_next = 32'h0;
            else                                          count_next = count_reg + 32'd1;
        end

        if (wr_ok) begin
            if (sel[REG_CTRL])     ctrl_next     = merged[CTRL_W-1:0];
            if (sel[REG_COUNT])    count_next    = merged;   // bus beats the tick
            if (sel[REG_COMPARE])  compare_next  = merged;
            if (sel[REG_PRESCALE]) prescale_next = merged[PRESCALE_W-1:0];
            // MATCH lives in lane 0, so only a lane-0 write can clear it
            if (sel[REG_STATUS] && byte_en[0] && wdata_lane[0]) match_next = 1'b0;
        end

        if (match_hit) begin
            match_next = 1'b1;   // a set outranks a same-cycle clear
        end
    end

    assign irq_next   = match_next & ctrl_next[CTRL_IRQ_EN];
    assign rdata_next = rd_ok ? ((reg_rd >> rd_shift) & size_mask(i_HB)) : 32'h0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_reg     <= '0;
            match_reg    <= 1'b0;
            count_reg    <= 32'h0;
            compare_reg  <= COMPARE_RST;
            prescale_reg <= '0;
            psc_cnt_reg  <= '0;
            o_RDATA      <= 32'h0;
            o_ACK        <= 1'b0;
            o_ERR        <= 1'b0;
            o_IRQ        <= 1'b0;
        end else begin
            ctrl_reg     <= ctrl_next;
            match_reg    <= match_next;
            count_reg    <= count_next;
            compare_reg  <= compare_next;
            prescale_reg <= prescale_next;
            psc_cnt_reg  <= psc_cnt_next;
            o_RDATA      <= rdata_next;
            o_ACK        <= acc;
            o_ERR        <= acc & acc_err;
            o_IRQ        <= irq_next;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer
//   Directed bench for bus_timer: a vector table for the register-file
//   decode and error paths, then hand-written sequences for the timer,
//   auto-reload, W1C, write-on-tick and mid-access reset cases.
module tb_bus_timer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_CS = 1'b0;
    logic [31:0] i_ADDR = 32'h0;
    logic [31:0] i_WDATA = 32'h0;
    logic        i_WE = 1'b0;
    logic        i_RE = 1'b0;
    logic [1:0]  i_HB = 2'b10;
    logic [31:0] o_RDATA;
    logic        o_ACK, o_ERR, o_IRQ;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_rdata;
    logic        got_ack, got_err;

    bus_timer dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_CS    (i_CS),
        .i_ADDR  (i_ADDR),
        .i_WDATA (i_WDATA),
        .i_WE    (i_WE),
        .i_RE    (i_RE),
        .i_HB    (i_HB),
        .o_RDATA (o_RDATA),
        .o_ACK   (o_ACK),
        .o_ERR   (o_ERR),
        .o_IRQ   (o_IRQ)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [1:0]  hb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus access: driven after a falling edge, accepted at the next
    // rising edge, response captured 1 time unit after that edge.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic re, input logic [1:0] hb);
        @(negedge i_clk);
        i_CS = 1'b1; i_ADDR = addr; i_WDATA = wdata; i_WE = we; i_RE = re; i_HB = hb;
        @(posedge i_clk);
        #1;
        i_CS = 1'b0; i_WE = 1'b0; i_RE = 1'b0;
        got_rdata = o_RDATA; got_ack = o_ACK; got_err = o_ERR;
        $display("txn addr=%h we=%b re=%b hb=%b wdata=%h -> rdata=%h ack=%b err=%b irq=%b",
                 addr, we, re, hb, wdata, got_rdata, got_ack, got_err, o_IRQ);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        bus(addr, wdata, 1'b1, 1'b0, 2'b10);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus(addr, 32'h0, 1'b0, 1'b1, 2'b10);
        chk({name, "_ack"}, 32'(got_ack), 32'd1);
        chk(name, got_rdata, exp);
    endtask

    task automatic add(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic re, input logic [1:0] hb,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.addr = addr; v.wdata = wdata; v.we = we; v.re = re; v.hb = hb;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // ---------------- reset state
        #1;
        chk("rst_ack",   32'(o_ACK), 32'd0);
        chk("rst_err",   32'(o_ERR), 32'd0);
        chk("rst_irq",   32'(o_IRQ), 32'd0);
        chk("rst_rdata", o_RDATA,    32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // ---------------- vector table (timer disabled throughout)
        add("rd_ctrl",     32'h00, 32'h0,        0, 1, 2'b10, 32'h0000_0000, 0);
        add("rd_status",   32'h04, 32'h0,        0, 1, 2'b10, 32'h0000_0000, 0);
        add("rd_count",    32'h08, 32'h0,        0, 1, 2'b10, 32'h0000_0000, 0);
        add("rd_compare",  32'h0C, 32'h0,        0, 1, 2'b10, 32'hFFFF_FFFF, 0);
        add("rd_prescale", 32'h10, 32'h0,        0, 1, 2'b10, 32'h0000_0000, 0);
        add("wr_count",    32'h08, 32'h11223344, 1, 0, 2'b10, 32'h0000_0000, 0);
        add("wr_byte_0a",  32'h0A, 32'h0000_00AB, 1, 0, 2'b00, 32'h0000_0000, 0);
        add("rd_count_m",  32'h08, 32'h0,        0, 1, 2'b10, 32'h11AB_3344, 0);
        add("rd_half_0a",  32'h0A, 32'h0,        0, 1, 2'b01, 32'h0000_11AB, 0);
        add("rd_byte_0b",  32'h0B, 32'h0,        0, 1, 2'b00, 32'h0000_0011, 0);
        add("rd_byte_09",  32'h09, 32'h0,        0, 1, 2'b00, 32'h0000_0033, 0);
        add("err_half_05", 32'h05, 32'h0,        0, 1, 2'b01, 32'h0000_0000, 1);
        add("err_hb11",    32'h08, 32'h0,        0, 1, 2'b11, 32'h0000_0000, 1);
        add("err_unmap",   32'h14, 32'h0,        0, 1, 2'b10, 32'h0000_0000, 1);
        add("err_we_re",   32'h08, 32'h0,        1, 1, 2'b10, 32'h0000_0000, 1);
        add("err_wr_hb11", 32'h08, 32'h0,        1, 0, 2'b11, 32'h0000_0000, 1);
        add("err_wr_mis",  32'h0A, 32'h0,        1, 0, 2'b10, 32'h0000_0000, 1);
        add("err_wr_unm",  32'h1C, 32'h5555_5555, 1, 0, 2'b10, 32'h0000_0000, 1);
        add("rd_count_ok", 32'h08, 32'h0,        0, 1, 2'b10, 32'h11AB_3344, 0);
        add("wr_half_0e",  32'h0E, 32'h0000_BEEF, 1, 0, 2'b01, 32'h0000_0000, 0);
        add("rd_cmp_half", 32'h0C, 32'h0,        0, 1, 2'b10, 32'hBEEF_FFFF, 0);
        add("wr_ctrl_hi",  32'h00, 32'hFFFF_FFF8, 1, 0, 2'b10, 32'h0000_0000, 0);
        add("rd_ctrl_0",   32'h00, 32'h0,        0, 1, 2'b10, 32'h0000_0000, 0);
        add("wr_psc",      32'h10, 32'h1234_5678, 1, 0, 2'b10, 32'h0000_0000, 0);
        add("rd_psc",      32'h10, 32'h0,        0, 1, 2'b10, 32'h0000_5678, 0);

        foreach (vecs[i]) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].hb);
            chk({vecs[i].name, "_ack"}, 32'(got_ack), 32'd1);
            chk({vecs[i].name, "_err"}, 32'(got_err), 32'(vecs[i].exp_err));
            chk(vecs[i].name, got_rdata, vecs[i].exp_rdata);
        end

        // ACK is a single-cycle pulse
        @(posedge i_clk); #1;
        chk("ack_one_cycle", 32'(o_ACK), 32'd0);

        // ---------------- prescaled match with IRQ
        wr(32'h08, 32'd0);          // COUNT
        wr(32'h10, 32'd3);          // PRESCALE
        wr(32'h0C, 32'd5);          // COMPARE
        wr(32'h00, 32'b011);        // EN | IRQ_EN
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge i_clk); #1;
            if (o_IRQ) begin
                n = k;
                break;
            end
        end
        chk("irq_latency", 32'(n), 32'd24);
        wr(32'h00, 32'b010);        // stop counting, keep IRQ_EN
        rd_chk("count_after_match", 32'h08, 32'd6);
        rd_chk("status_match", 32'h04, 32'd1);
        chk("irq_level", 32'(o_IRQ), 32'd1);

        // ---------------- auto reload, W1C
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd2);
        wr(32'h10, 32'd0);
        wr(32'h00, 32'b111);
        rd_chk("ar_count0", 32'h08, 32'd0);
        rd_chk("ar_count1", 32'h08, 32'd1);
        rd_chk("ar_count2", 32'h08, 32'd2);
        rd_chk("ar_count3", 32'h08, 32'd0);
        rd_chk("ar_count4", 32'h08, 32'd1);
        rd_chk("ar_count5", 32'h08, 32'd2);
        wr(32'h00, 32'b010);
        rd_chk("ar_status", 32'h04, 32'd1);
        bus(32'h05, 32'h01, 1'b1, 1'b0, 2'b00);   // lane 1 write cannot clear MATCH
        rd_chk("w1c_wrong_lane", 32'h04, 32'd1);
        chk("irq_before_w1c", 32'(o_IRQ), 32'd1);
        wr(32'h04, 32'h1);
        chk("irq_after_w1c", 32'(o_IRQ), 32'd0);
        rd_chk("status_cleared", 32'h04, 32'd0);

        // ---------------- COUNT write on a tick cycle
        wr(32'h0C, 32'hFFFF_0000);
        wr(32'h00, 32'b001);        // PRESCALE=0: every cycle ticks
        wr(32'h08, 32'h100);
        rd_chk("count_wr_wins", 32'h08, 32'h100);
        wr(32'h00, 32'b000);

        // ---------------- pending ACK dropped by async reset
        wr(32'h00, 32'b110);
        wr(32'h10, 32'd7);
        @(negedge i_clk);
        i_CS = 1'b1; i_ADDR = 32'h0C; i_WE = 1'b0; i_RE = 1'b1; i_HB = 2'b10;
        @(posedge i_clk); #1;
        i_CS = 1'b0; i_RE = 1'b0;
        chk("pre_rst_ack", 32'(o_ACK), 32'd1);
        i_rst = 1'b1;
        #1;
        chk("rst_drops_ack", 32'(o_ACK), 32'd0);
        chk("rst_drops_rdata", o_RDATA, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // ---------------- reset asserted while a write is presented
        wr(32'h00, 32'b010);
        @(negedge i_clk);
        i_CS = 1'b1; i_ADDR = 32'h08; i_WDATA = 32'hDEAD_BEEF; i_WE = 1'b1; i_HB = 2'b10;
        #2;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_mid_ack", 32'(o_ACK), 32'd0);
        i_CS = 1'b0; i_WE = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_irq_low", 32'(o_IRQ), 32'd0);
        rd_chk("rst_ctrl",     32'h00, 32'h0);
        rd_chk("rst_status",   32'h04, 32'h0);
        rd_chk("rst_count",    32'h08, 32'h0);
        rd_chk("rst_compare",  32'h0C, 32'hFFFF_FFFF);
        rd_chk("rst_prescale", 32'h10, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped timer peripheral; the responder end of the core's load/store bus.
- Decodes word, halfword and byte accesses that the LSU issues (address, write data, WE/RE, HB size) into a small register file.
- Returns read data right-justified, with a registered acknowledge.
- Contains a prescaled 32-bit up-counter with compare-match and an interrupt output to the core.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and prescaler counter.
- COMPARE_RST, 32'hFFFF_FFFF, reset value of COMPARE.
- OFFS_W, 5, address bits decoded inside the block (i_ADDR[OFFS_W-1:0]).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_CS  in  1  slave select from the interconnect (address decoded above this block).
- i_ADDR  in  32  byte address; only [OFFS_W-1:0] used.
- i_WDATA  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- i_WE  in  1  write strobe.
- i_RE  in  1  read strobe.
- i_HB  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- o_RDATA  out  32  read data, right-justified, zero-extended; valid while o_ACK=1.
- o_ACK  out  1  one-cycle pulse, cycle after an accepted access.
- o_ERR  out  1  qualifies o_ACK: access rejected.
- o_IRQ  out  1  interrupt level to the core.

Behaviour:
- Reset, asynchronous, all registered:
  - CTRL=0, STATUS=0, COUNT=0, COMPARE=COMPARE_RST, PRESCALE=0, prescaler counter=0.
  - o_RDATA=0, o_ACK=0, o_ERR=0, o_IRQ=0.
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD; other bits read 0.
  - 0x04 STATUS: [0] MATCH, sticky; writing 1 clears it (W1C).
  - 0x08 COUNT, read/write.
  - 0x0C COMPARE, read/write.
  - 0x10 PRESCALE, [PRESCALE_W-1:0].
  - Other offsets are unmapped.
- Access acceptance: an access is accepted when i_CS & (i_WE|i_RE) is sampled at a rising edge. o_ACK=1 on the next cycle for exactly one cycle. Back-to-back accesses give back-to-back ACKs (no wait states).
- Errors (o_ERR=1 with ACK, no state change, o_RDATA=0):
  - HB=11.
  - Misalignment: half with ADDR[0]=1, word with ADDR[1:0]!=0.
  - Unmapped offset.
  - i_WE & i_RE both high.
- Writes:
  - Byte and half data are steered to lane ADDR[1:0] and merged into the target register.
  - Bits not implemented in the target are ignored.
  - STATUS W1C applies per written lane only.
- Reads:
  - Register sampled at the accepting edge; lane ADDR[1:0] is shifted down and zero-extended into o_RDATA.
  - Sign extension is the core's job, not this block's.
- Prescaler:
  - While EN=1 the prescaler counter increments each cycle.
  - When it equals PRESCALE it returns to 0 and emits a tick. PRESCALE=0 therefore ticks every cycle.
  - EN=0 freezes the prescaler and COUNT.
- On tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 if AUTO_RELOAD, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - 32'hFFFF_FFFF wraps to 0 with no flag.
- Simultaneous events:
  - A bus write to COUNT on a tick cycle: the bus write wins and the increment is lost.
  - A MATCH set and a W1C of MATCH in the same cycle: the set wins.
  - A write to PRESCALE resets the prescaler counter to 0.
- o_IRQ is registered: o_IRQ <= MATCH_next & IRQ_EN_next. It asserts the cycle after MATCH sets (IRQ_EN=1) and is level until cleared.
- Reset mid-access: a pending ACK is dropped and no write occurs.

Decomposition:
- Shared package/header (Core.vh companion): HB size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), timer register offsets, CTRL bit indices.
- Sub-module bus_lane_ctrl (combinational):
  - Inputs ADDR[1:0], HB, WE, RE.
  - Outputs byte-enable[3:0], misalign/err flag, read shift amount.
  - Reused by later bus peripherals.

Test Plan:
- Reset, then word reads of 0x00–0x10 -> ACK one cycle later each, ERR=0; data 0, 0, 0, FFFF_FFFF, 0.
- Write COUNT=0x11223344, then byte write 0xAB at 0x0A, then read 0x08 -> 0x11AB3344; half read at 0x0A -> 0x000011AB.
- PRESCALE=3, COMPARE=5, CTRL=0b011 -> MATCH set after 24 enabled cycles; o_IRQ high the next cycle; COUNT continues 6, 7, ...
- AUTO_RELOAD=1, COMPARE=2, PRESCALE=0 -> COUNT sequence 0, 1, 2, 0, 1, 2; MATCH stays 1; W1C 0x1 to STATUS clears it and o_IRQ drops next cycle.
- Errors: half access at 0x05, HB=11, read at 0x14, WE&RE together -> each gives ACK with ERR=1, RDATA=0, no register changes.
- COUNT written on a tick cycle with value 0x100 -> COUNT=0x100, not 0x101. Async reset asserted mid-access -> no ACK and all registers at reset values.
